// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: handshake and data bus between the AES round
// sequencer (slave) and its controller / round datapath / key schedule (master).
interface aes_round_sequencer_if #(
   parameter int DATA_W = 128
) ();
   logic              start;
   logic              encrypt;
   logic [1:0]        key_len;
   logic              abort;
   logic [DATA_W-1:0] Rx_SR;
   logic [DATA_W-1:0] round_key;
   logic [DATA_W-1:0] encrypted;
   logic [DATA_W-1:0] decrypted;
   logic              busy;
   logic              done;
   logic              load_enable;
   logic              last_round;
   logic [3:0]        round;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] Tx_SR;
   logic              err;

   modport master (
      output start, encrypt, key_len, abort, Rx_SR, round_key, encrypted, decrypted,
      input  busy, done, load_enable, last_round, round, data, Tx_SR, err
   );

   modport slave (
      input  start, encrypt, key_len, abort, Rx_SR, round_key, encrypted, decrypted,
      output busy, done, load_enable, last_round, round, data, Tx_SR, err
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES-128/192/256 encrypt/decrypt round sequencer.
// Holds the cipher state, drives the round-key index and round control; the
// external round datapath and key schedule close the loop through the bus.
// Optional feature: define AES_ABORT_EN to honour the synchronous abort input.
module aes_round_sequencer #(
   parameter int DATA_W = 128,
   parameter int PHASES = 2
) (
   input  logic                 clk,
   input  logic                 n_rst,
   aes_round_sequencer_if.slave bus
);
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PHASES - 1);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROUND, S_DONE} state_t;

   state_t            r_state;
   logic              r_enc;
   logic [3:0]        r_nr;
   logic [3:0]        r_k;
   logic [PW-1:0]     r_phase;
   logic [3:0]        r_round;
   logic              r_busy;
   logic              r_done;
   logic              r_last;
   logic              r_err;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_tx;

   logic [3:0]        w_nr;
   logic              w_abort;
   logic [DATA_W-1:0] w_next;

   // Round count for the requested key length (reserved code never accepted)
   always_comb begin
      case (bus.key_len)
         2'b00:   w_nr = 4'd10;
         2'b01:   w_nr = 4'd12;
         default: w_nr = 4'd14;
      endcase
   end

`ifdef AES_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_next = r_enc ? bus.encrypted : bus.decrypted;

   // Sequencer FSM with round/phase counters and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_enc   <= 1'b0;
         r_nr    <= 4'd10;
         r_k     <= '0;
         r_phase <= '0;
         r_round <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_tx    <= '0;
      end else begin
         r_err <= 1'b0;
         // Abort overrides everything, including a start in IDLE and a capture edge
         if (w_abort) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_round <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start) begin
                     if (bus.key_len == 2'b11) begin
                        r_err <= 1'b1;
                     end else begin
                        r_state <= S_INIT;
                        r_enc   <= bus.encrypt;
                        r_nr    <= w_nr;
                        r_busy  <= 1'b1;
                        r_round <= bus.encrypt ? 4'd0 : w_nr;
                     end
                  end
               end
               S_INIT: begin
                  r_data  <= bus.Rx_SR ^ bus.round_key;
                  r_state <= S_ROUND;
                  r_k     <= 4'd1;
                  r_phase <= '0;
                  r_round <= r_enc ? 4'd1 : r_nr - 4'd1;
                  r_last  <= 1'b0;
               end
               S_ROUND: begin
                  if (r_phase == P_LAST) begin
                     r_data  <= w_next;
                     r_phase <= '0;
                     if (r_k == r_nr) begin
                        r_tx    <= w_next;
                        r_state <= S_DONE;
                        r_round <= '0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_k     <= r_k + 4'd1;
                        r_round <= r_enc ? r_k + 4'd1 : r_nr - r_k - 4'd1;
                        r_last  <= (r_k + 4'd1 == r_nr);
                     end
                  end else begin
                     r_phase <= r_phase + 1'b1;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.load_enable = r_done;
   assign bus.last_round  = r_last;
   assign bus.round       = r_round;
   assign bus.data        = r_data;
   assign bus.Tx_SR       = r_tx;
   assign bus.err         = r_err;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: closes the loop around two sequencers (PHASES=2 and
// PHASES=1) with a behavioural AES round datapath and key schedule, and checks
// results against a whole-cipher reference model and FIPS-197 vectors.
module tb_aes_round_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic n_rst;

   aes_round_sequencer_if #(.DATA_W(128)) if2 ();
   aes_round_sequencer_if #(.DATA_W(128)) if1 ();

   aes_round_sequencer #(.DATA_W(128), .PHASES(2)) dut2 (.clk(clk), .n_rst(n_rst), .bus(if2));
   aes_round_sequencer #(.DATA_W(128), .PHASES(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));

   int n_pass   = 0;
   int n_checks = 0;

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   // ---------------- AES arithmetic ----------------
   logic [7:0]   sbox  [0:255];
   logic [7:0]   isbox [0:255];
   logic [127:0] rk    [0:15];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = xt(x);
      end
      return r;
   endfunction

   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         logic [7:0] s;
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox[a]  = s;
         isbox[s] = 8'(a);
      end
   endtask

   function automatic logic [127:0] sub_b(input logic [127:0] x, input bit inv);
      logic [127:0] y;
      for (int i = 0; i < 16; i++)
         y[127-8*i -: 8] = inv ? isbox[x[127-8*i -: 8]] : sbox[x[127-8*i -: 8]];
      return y;
   endfunction

   function automatic logic [127:0] shift_r(input logic [127:0] x, input bit inv);
      logic [127:0] y;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            int s;
            s = inv ? (c - r + 4) % 4 : (c + r) % 4;
            y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*s) -: 8];
         end
      return y;
   endfunction

   function automatic logic [127:0] mix_c(input logic [127:0] x, input bit inv);
      logic [127:0] y;
      logic [7:0]   m [4];
      logic [7:0]   a [4];
      logic [7:0]   b;
      if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
      else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = x[127-8*(4*c+j) -: 8];
         for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gm(a[j], m[(j - r + 4) % 4]);
            y[127-8*(4*c+r) -: 8] = b;
         end
      end
      return y;
   endfunction

   function automatic logic [127:0] enc_round(input logic [127:0] d, input logic [127:0] k, input logic last);
      logic [127:0] t;
      t = shift_r(sub_b(d, 1'b0), 1'b0);
      if (!last) t = mix_c(t, 1'b0);
      return t ^ k;
   endfunction

   function automatic logic [127:0] dec_round(input logic [127:0] d, input logic [127:0] k, input logic last);
      logic [127:0] t;
      t = sub_b(shift_r(d, 1'b1), 1'b1) ^ k;
      if (!last) t = mix_c(t, 1'b1);
      return t;
   endfunction

   function automatic logic [31:0] sub_w(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   // Key schedule: key is left-aligned, nk = 4/6/8 words
   task automatic expand_key(input logic [255:0] key, input int nk);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
               t = sub_w(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r < 16; r++)
         if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         rk[r] = '0;
   endtask

   // Whole-cipher reference
   function automatic logic [127:0] aes_ref(input logic [127:0] blk, input bit enc, input int nr);
      logic [127:0] s;
      if (enc) begin
         s = blk ^ rk[0];
         for (int r = 1; r <= nr; r++) s = enc_round(s, rk[r], r == nr);
      end else begin
         s = blk ^ rk[nr];
         for (int r = nr - 1; r >= 0; r--) s = dec_round(s, rk[r], r == 0);
      end
      return s;
   endfunction

   // External round datapath and key lookup for both sequencers
   assign if2.round_key = rk[if2.round];
   assign if1.round_key = rk[if1.round];
   always_comb begin
      if2.encrypted = enc_round(if2.data, if2.round_key, if2.last_round);
      if2.decrypted = dec_round(if2.data, if2.round_key, if2.last_round);
      if1.encrypted = enc_round(if1.data, if1.round_key, if1.last_round);
      if1.decrypted = dec_round(if1.data, if1.round_key, if1.last_round);
   end

   // Expected per-cycle behaviour; cycle c counts from the edge that samples start
   function automatic logic [3:0] exp_round(input int c, input bit enc, input int nr, input int p);
      int k;
      if (c == 1) return enc ? 4'd0 : 4'(nr);
      if (c >= 2 && c <= 1 + nr * p) begin
         k = (c - 2) / p + 1;
         return enc ? 4'(k) : 4'(nr - k);
      end
      return 4'd0;
   endfunction

   // {busy, last_round, done, load_enable}
   function automatic logic [3:0] exp_ctrl(input int c, input int nr, input int p);
      logic b, l, d;
      b = (c >= 1 && c <= 2 + nr * p);
      l = (c >= 2 + (nr - 1) * p && c <= 1 + nr * p);
      d = (c == 2 + nr * p);
      return {b, l, d, d};
   endfunction

   // ---------------- observation of one PHASES=2 operation ----------------
   logic [3:0]   q_round [$];
   logic [3:0]   q_ctrl  [$];
   logic [127:0] q_data  [$];
   int           done_cyc;
   int           done_cnt;
   logic [127:0] tx_end;

   task automatic run2(input logic [127:0] blk, input bit enc, input logic [1:0] kl,
                       input int abort_at, input int limit);
      q_round.delete(); q_ctrl.delete(); q_data.delete();
      done_cyc = 0;
      done_cnt = 0;
      @(negedge clk);
      if2.Rx_SR   = blk;
      if2.encrypt = enc;
      if2.key_len = kl;
      if2.start   = 1'b1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         q_round.push_back(if2.round);
         q_ctrl.push_back({if2.busy, if2.last_round, if2.done, if2.load_enable});
         q_data.push_back(if2.data);
         if (if2.done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (c == 1) begin
            if2.start   = 1'b0;
            if2.encrypt = 1'($urandom);
            if2.key_len = 2'($urandom);
         end
         if2.abort = (c == abort_at);
      end
      if2.abort = 1'b0;
      tx_end = if2.Tx_SR;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_rst = 1'b0;
      #12;
      n_checks++;
      if ({if2.busy, if2.done, if2.load_enable, if2.last_round, if2.err, if2.round} !== 9'd0)
         $display("FAIL reset_ctrl2: got %b want 0", {if2.busy, if2.done, if2.load_enable, if2.last_round, if2.err, if2.round});
      else n_pass++;
      n_checks++;
      if ({if2.data, if2.Tx_SR} !== 256'd0) $display("FAIL reset_data2: got %h %h want 0", if2.data, if2.Tx_SR);
      else n_pass++;
      n_checks++;
      if ({if1.busy, if1.done, if1.load_enable, if1.last_round, if1.err, if1.round, if1.data, if1.Tx_SR} !== 265'd0)
         $display("FAIL reset_all1: got busy=%b round=%0d tx=%h want 0", if1.busy, if1.round, if1.Tx_SR);
      else n_pass++;
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_enc128();
      expand_key(KEY & {128'hffffffffffffffffffffffffffffffff, 128'h0}, 4);
      run2(PT, 1'b1, 2'b00, 0, 24);
      n_checks++;
      if (done_cyc != 22) $display("FAIL enc128_latency: got %0d want 22", done_cyc); else n_pass++;
      n_checks++;
      if (done_cnt != 1) $display("FAIL enc128_done_count: got %0d want 1", done_cnt); else n_pass++;
      n_checks++;
      if (tx_end !== CT128) $display("FAIL enc128_tx: got %h want %h", tx_end, CT128); else n_pass++;
      for (int c = 1; c <= 24; c++) begin
         n_checks++;
         if (q_round[c-1] !== exp_round(c, 1'b1, 10, 2))
            $display("FAIL enc128_round c%0d: got %0d want %0d", c, q_round[c-1], exp_round(c, 1'b1, 10, 2));
         else n_pass++;
         n_checks++;
         if (q_ctrl[c-1] !== exp_ctrl(c, 10, 2))
            $display("FAIL enc128_ctrl c%0d: got %b want %b", c, q_ctrl[c-1], exp_ctrl(c, 10, 2));
         else n_pass++;
      end
   endtask

   task automatic test_dec256();
      expand_key(KEY, 8);
      run2(CT256, 1'b0, 2'b10, 0, 32);
      n_checks++;
      if (done_cyc != 30) $display("FAIL dec256_latency: got %0d want 30", done_cyc); else n_pass++;
      n_checks++;
      if (tx_end !== PT) $display("FAIL dec256_tx: got %h want %h", tx_end, PT); else n_pass++;
      for (int c = 1; c <= 32; c++) begin
         n_checks++;
         if (q_round[c-1] !== exp_round(c, 1'b0, 14, 2))
            $display("FAIL dec256_round c%0d: got %0d want %0d", c, q_round[c-1], exp_round(c, 1'b0, 14, 2));
         else n_pass++;
         n_checks++;
         if (q_ctrl[c-1] !== exp_ctrl(c, 14, 2))
            $display("FAIL dec256_ctrl c%0d: got %b want %b", c, q_ctrl[c-1], exp_ctrl(c, 14, 2));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         logic [1:0]   kl;
         logic [255:0] key;
         logic [127:0] blk;
         logic [127:0] exp;
         bit           enc;
         int           nr;
         kl  = 2'($urandom_range(0, 2));
         nr  = 10 + 2 * int'(kl);
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         blk = {$urandom, $urandom, $urandom, $urandom};
         enc = 1'($urandom);
         expand_key(key, 4 + 2 * int'(kl));
         exp = aes_ref(blk, enc, nr);
         run2(blk, enc, kl, 0, 2 + nr * 2 + 2);
         n_checks++;
         if (done_cyc != 2 + nr * 2)
            $display("FAIL rand%0d_latency: got %0d want %0d", n, done_cyc, 2 + nr * 2);
         else n_pass++;
         n_checks++;
         if (tx_end !== exp) $display("FAIL rand%0d_tx: got %h want %h", n, tx_end, exp); else n_pass++;
      end
   endtask

   task automatic test_reserved();
      logic [127:0] prior;
      prior = if2.Tx_SR;
      @(negedge clk);
      if2.key_len = 2'b11;
      if2.start   = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      n_checks++;
      if ({if2.err, if2.busy} !== 2'b10) $display("FAIL reserved_err: got err/busy %b want 10", {if2.err, if2.busy});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({if2.err, if2.busy} !== 2'b00) $display("FAIL reserved_after: got err/busy %b want 00", {if2.err, if2.busy});
      else n_pass++;
      n_checks++;
      if (if2.Tx_SR !== prior) $display("FAIL reserved_tx: got %h want %h", if2.Tx_SR, prior); else n_pass++;
   endtask

   task automatic test_abort();
      logic [127:0] prior;
      prior = if2.Tx_SR;
      expand_key(KEY & {192'hffffffffffffffffffffffffffffffffffffffffffffffff, 64'h0}, 6);
      run2(PT, 1'b1, 2'b01, 7, 28);
`ifdef AES_ABORT_EN
      n_checks++;
      if (done_cnt != 0) $display("FAIL abort_no_done: got %0d want 0", done_cnt); else n_pass++;
      n_checks++;
      if (q_ctrl[6][3] !== 1'b1) $display("FAIL abort_busy_c7: got %b want 1", q_ctrl[6][3]); else n_pass++;
      n_checks++;
      if ({q_ctrl[7], q_round[7]} !== 8'd0) $display("FAIL abort_idle_c8: got %b want 0", {q_ctrl[7], q_round[7]});
      else n_pass++;
      n_checks++;
      if (q_data[7] !== q_data[6]) $display("FAIL abort_data: got %h want %h", q_data[7], q_data[6]); else n_pass++;
      n_checks++;
      if (tx_end !== prior) $display("FAIL abort_tx: got %h want %h", tx_end, prior); else n_pass++;
      // abort together with start in IDLE drops the start
      @(negedge clk);
      if2.key_len = 2'b00;
      if2.start   = 1'b1;
      if2.abort   = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      if2.abort = 1'b0;
      n_checks++;
      if ({if2.busy, if2.err} !== 2'b00) $display("FAIL abort_start_idle: got busy/err %b want 00", {if2.busy, if2.err});
      else n_pass++;
`else
      n_checks++;
      if (done_cyc != 26) $display("FAIL abort_ignored_latency: got %0d want 26", done_cyc); else n_pass++;
      n_checks++;
      if (tx_end !== CT192) $display("FAIL abort_ignored_tx: got %h want %h", tx_end, CT192); else n_pass++;
      n_checks++;
      if (q_ctrl[7][3] !== 1'b1) $display("FAIL abort_ignored_busy_c8: got %b want 1", q_ctrl[7][3]); else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      expand_key(KEY & {128'hffffffffffffffffffffffffffffffff, 128'h0}, 4);
      @(negedge clk);
      if2.Rx_SR   = PT;
      if2.encrypt = 1'b1;
      if2.key_len = 2'b00;
      if2.start   = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      repeat (6) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      n_checks++;
      if ({if2.busy, if2.done, if2.load_enable, if2.last_round, if2.err, if2.round, if2.data, if2.Tx_SR} !== 265'd0)
         $display("FAIL reset_mid_async: got busy=%b round=%0d data=%h tx=%h want 0", if2.busy, if2.round, if2.data, if2.Tx_SR);
      else n_pass++;
      @(negedge clk);
      n_rst = 1'b1;
      run2(PT, 1'b1, 2'b00, 0, 24);
      n_checks++;
      if (done_cyc != 22) $display("FAIL reset_mid_latency: got %0d want 22", done_cyc); else n_pass++;
      n_checks++;
      if (tx_end !== CT128) $display("FAIL reset_mid_tx: got %h want %h", tx_end, CT128); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int           d1, d2;
      logic [127:0] tx13, tx26;
      logic         busy13;
      logic [3:0]   r1 [$];
      d1 = 0; d2 = 0;
      expand_key(KEY & {128'hffffffffffffffffffffffffffffffff, 128'h0}, 4);
      @(negedge clk);
      if1.Rx_SR   = PT;
      if1.encrypt = 1'b1;
      if1.key_len = 2'b00;
      if1.start   = 1'b1;
      for (int c = 1; c <= 28; c++) begin
         @(negedge clk);
         if (c <= 12) r1.push_back(if1.round);
         if (if1.done) begin
            if (d1 == 0) d1 = c;
            else if (d2 == 0) d2 = c;
         end
         if (c == 13) begin tx13 = if1.Tx_SR; busy13 = if1.busy; end
         if (c == 26) tx26 = if1.Tx_SR;
         if (c == 14) if1.start = 1'b0;
      end
      n_checks++;
      if (d1 != 12) $display("FAIL b2b_first_done: got %0d want 12", d1); else n_pass++;
      n_checks++;
      if (d2 != 25) $display("FAIL b2b_second_done: got %0d want 25", d2); else n_pass++;
      n_checks++;
      if (busy13 !== 1'b0) $display("FAIL b2b_idle_gap: got busy %b want 0", busy13); else n_pass++;
      n_checks++;
      if (tx13 !== CT128) $display("FAIL b2b_tx1: got %h want %h", tx13, CT128); else n_pass++;
      n_checks++;
      if (tx26 !== CT128) $display("FAIL b2b_tx2: got %h want %h", tx26, CT128); else n_pass++;
      for (int c = 1; c <= 12; c++) begin
         n_checks++;
         if (r1[c-1] !== exp_round(c, 1'b1, 10, 1))
            $display("FAIL b2b_round c%0d: got %0d want %0d", c, r1[c-1], exp_round(c, 1'b1, 10, 1));
         else n_pass++;
      end
   endtask

   initial begin
      build_sbox();
      for (int r = 0; r < 16; r++) rk[r] = '0;
      if2.start = 1'b0; if2.encrypt = 1'b1; if2.key_len = 2'b00; if2.abort = 1'b0; if2.Rx_SR = '0;
      if1.start = 1'b0; if1.encrypt = 1'b1; if1.key_len = 2'b00; if1.abort = 1'b0; if1.Rx_SR = '0;
      test_reset();
      test_enc128();
      test_dec256();
      test_random();
      test_reserved();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Parametrised round sequencer for the AES accelerator. It runs AES-128, AES-192 or AES-256 encrypt and decrypt, with a configurable number of cycles per round. The block holds the 128-bit cipher state register and drives the round-key index and round control. The external round datapath and key schedule close the loop.

## Interface
- `DATA_W`, 128: state width; only 128 is legal.
- `PHASES`, 2: cycles per round (≥1); the state is captured on the last phase.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `encrypt`  in  1  1 = encrypt, 0 = decrypt; latched at accepted start.
- `key_len`  in  2  00 = 128-bit (Nr=10), 01 = 192-bit (Nr=12), 10 = 256-bit (Nr=14), 11 = reserved; latched at accepted start.
- `abort`  in  1  synchronous cancel (see Configuration).
- `Rx_SR`  in  DATA_W  input block (plaintext or ciphertext).
- `round_key`  in  DATA_W  key for the current `round` index.
- `encrypted`  in  DATA_W  external encrypt-round output, computed from `data`.
- `decrypted`  in  DATA_W  external decrypt-round output, computed from `data`.
- `busy`  out  1  high in INIT, ROUND and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `load_enable`  out  1  equals `done`; `Tx_SR` is valid to load downstream.
- `last_round`  out  1  high throughout the final round's phases.
- `round`  out  4  round-key index.
- `data`  out  DATA_W  registered cipher state.
- `Tx_SR`  out  DATA_W  registered result, held until the next completion.
- `err`  out  1  one-cycle pulse when start is rejected.

## Operation
- **States:**
  - IDLE → INIT on `start` with `key_len`≠11.
  - INIT → ROUND after 1 cycle.
  - ROUND → DONE at the end of the last phase of the final round.
  - DONE → IDLE after 1 cycle.
- **Start handling:**
  - `start` with `key_len`=11 in IDLE: stay in IDLE; `err`=1 next cycle.
  - `start` outside IDLE is ignored.
- **INIT:**
  - `round` = 0 (encrypt) or Nr (decrypt).
  - `data` ← `Rx_SR` ^ `round_key` at the INIT→ROUND edge.
- **ROUND counters:**
  - Round counter k runs 1..Nr.
  - Phase counter p runs 0..PHASES-1 and wraps to 0 when k advances.
  - `round` = k (encrypt) or Nr-k (decrypt).
- **State capture in ROUND:**
  - At p=PHASES-1, `data` ← `encrypted` (encrypt) or `decrypted` (decrypt).
  - At the same edge for k=Nr, `Tx_SR` also ← the same value.
- **Mode inputs:** `last_round` = (k==Nr) in ROUND. `encrypt` and `key_len` changes after acceptance have no effect.
- **Held outputs:** `data` holds outside capture edges. `round` = 0 in IDLE and DONE.

## Timing
- **Reset values:**
  - State = IDLE.
  - `data`, `Tx_SR` = 0.
  - `round` = 0.
  - `busy`, `done`, `load_enable`, `last_round`, `err` = 0.
- **Latency:** `start` sampled at edge 0.
  - INIT occupies cycle 1.
  - ROUND occupies cycles 2..1+Nr·PHASES.
  - `done` is high in cycle 2+Nr·PHASES.
  - Examples: 22 cycles for AES-128 with PHASES=2; 30 for AES-256.
- **Back-to-back:** `start` in the DONE cycle is ignored. The earliest new start is sampled at the first IDLE edge, so there is 1 idle cycle minimum between operations.
- **Abort:**
  - `abort` in any busy state: IDLE next edge; no `done`.
  - `data` keeps its last value; `Tx_SR` is unchanged.
  - `abort` and `start` together in IDLE: abort wins, start is dropped.
- **Reset mid-operation:** immediate return to reset values; no `done`.
- **PHASES=1:** the phase counter is a constant 0 and capture happens every ROUND cycle.

## Configuration
- `AES_ABORT_EN` defined: `abort` behaves as specified.
- `AES_ABORT_EN` undefined: the `abort` port remains but is ignored; an operation always runs to DONE once started.

## Test plan
- **AES-128 encrypt:** key 000102..0f, `Rx_SR`=00112233445566778899aabbccddeeff, PHASES=2, with a bench round model → `Tx_SR`=69c4e0d86a7b0430d8cdb78070b4c55a; `done` 22 cycles after start; `round` sequence 0,1,1,2,2,…,10,10.
- **AES-256 decrypt:** `Rx_SR`=8ea2b7ca516745bfeafc49904b496089, key 000102..1f → `Tx_SR`=00112233445566778899aabbccddeeff; `round` 14,13,13,…,0,0; `last_round` high only in the final 2 ROUND cycles.
- **Reserved key length:** `key_len`=11 with `start` → `err` pulse; `busy` stays 0; `Tx_SR` unchanged.
- **Abort:** `abort` at cycle 7 of AES-192 encrypt → IDLE at cycle 8; `done` never asserts; `Tx_SR` keeps its prior result. Repeat with `AES_ABORT_EN` undefined → `done` at cycle 26.
- **Reset mid-run:** `n_rst` low during ROUND → all outputs 0 asynchronously; after release, a new AES-128 start completes in 22 cycles.
- **Back-to-back with PHASES=1:** `start` held high across DONE → the second operation begins one IDLE cycle later; each AES-128 run completes in 12 cycles.
